// File: rtl/getpixel_menu_pkg.sv
// Shared constants for the menu overlay: colours, title window, cursor geometry, control states.
// No logic; consumed by getpixel_menu and its sub-module.
// Backpressure: n/a.
package getpixel_menu_pkg;

    localparam logic [11:0] WHITE = 12'hfff;
    localparam logic [11:0] BLACK = 12'h000;
    localparam logic [11:0] RED   = 12'hf00;
    localparam logic [11:0] GREEN = 12'h0f0;

    localparam int TITLE_X0 = 32;
    localparam int TITLE_X1 = 405;
    localparam int TITLE_Y0 = 16;
    localparam int TITLE_Y1 = 39;

    localparam int CURSOR_X = 64;
    localparam int CURSOR_W = 26;
    localparam int CURSOR_H = 16;

    // Rows are drawn ROW_TRIM pixels shorter than their pitch, leaving a gap between boxes.
    localparam int ROW_TRIM = 28;

    typedef enum logic {
        BROWSE = 1'b0,
        LOCKED = 1'b1
    } menu_state_t;

endpackage

// File: rtl/menu_title_rom.sv
// Title bitmap lookup: 373x23 one-bit glyph field addressed relative to the title window.
// Latency: 1 clk synchronous read.
// Backpressure: none; a new address is accepted every cycle.
module menu_title_rom (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] x,
    input  logic [4:0] y,
    output logic       dout
);

    // Banded glyph pattern: alternating 8-pixel cells, one blank column per cell,
    // and a diagonal notch where the cell-pair index meets the row index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= 1'b0;
        end else begin
            dout <= (x[3] ^ y[2]) & (x[2:0] != 3'd7) & (x[8:4] != y);
        end
    end

endmodule

// File: rtl/getpixel_menu.sv
// Menu overlay: button-driven row selection with confirm/ack handshake and a pixel colour pipeline.
// Latency: 2 clk from h_cnt/v_cnt/valid to r/g/b.
// Backpressure: buttons are ignored while a confirmed selection awaits sel_ack.
module getpixel_menu
    import getpixel_menu_pkg::*;
#(
    parameter int N_ITEMS      = 4,
    parameter int SEL_W        = 2,
    parameter int BOX_X0       = 112,
    parameter int BOX_X1       = 592,
    parameter int BOX_Y0       = 88,
    parameter int ROW_PITCH    = 88,
    parameter int BORDER       = 5,
    parameter int BLINK_FRAMES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [9:0]       h_cnt,
    input  logic [9:0]       v_cnt,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_confirm,
    input  logic             sel_ack,
    output logic [SEL_W-1:0] sel,
    output logic             sel_valid,
    output logic [3:0]       r,
    output logic [3:0]       g,
    output logic [3:0]       b
);

    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(N_ITEMS - 1);
    localparam int               FC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FC_W-1:0]  FC_MAX  = FC_W'(BLINK_FRAMES - 1);

    localparam logic [10:0] BX0     = 11'(BOX_X0);
    localparam logic [10:0] BX1     = 11'(BOX_X1);
    localparam logic [10:0] BY0     = 11'(BOX_Y0);
    localparam logic [10:0] RP      = 11'(ROW_PITCH);
    localparam logic [10:0] BRD     = 11'(BORDER);
    localparam logic [10:0] ROW_H   = 11'(ROW_PITCH - ROW_TRIM);
    localparam logic [10:0] CUR_OFF = 11'((ROW_PITCH - ROW_TRIM) / 2 - CURSOR_H / 2);
    localparam logic [10:0] CUR_H   = 11'(CURSOR_H);
    localparam logic [10:0] CUR_X0  = 11'(CURSOR_X);
    localparam logic [10:0] CUR_X1  = 11'(CURSOR_X + CURSOR_W);
    localparam logic [10:0] TX0     = 11'(TITLE_X0);
    localparam logic [10:0] TX1     = 11'(TITLE_X1);
    localparam logic [10:0] TY0     = 11'(TITLE_Y0);
    localparam logic [10:0] TY1     = 11'(TITLE_Y1);

    menu_state_t     state;
    logic [FC_W-1:0] frame_cnt;
    logic            blink_phase;

    // Selection control: confirm wins over a simultaneous move, and the lock holds until ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= BROWSE;
            sel       <= '0;
            sel_valid <= 1'b0;
        end else begin
            case (state)
                BROWSE: begin
                    if (btn_confirm) begin
                        state     <= LOCKED;
                        sel_valid <= 1'b1;
                    end else if (btn_up && !btn_down) begin
                        sel <= (sel == '0) ? SEL_MAX : sel - SEL_W'(1);
                    end else if (btn_down && !btn_up) begin
                        sel <= (sel == SEL_MAX) ? '0 : sel + SEL_W'(1);
                    end
                end
                LOCKED: begin
                    if (sel_ack) begin
                        state     <= BROWSE;
                        sel_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= BROWSE;
                    sel_valid <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (h_cnt == 10'd0 && v_cnt == 10'd0) begin
            if (frame_cnt == FC_MAX) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + FC_W'(1);
            end
        end
    end

    logic [10:0] hx, vy, oy;
    logic        clipped, hit_outline, hit_cur_row, hit_cursor, hit_title;

    assign hx = {1'b0, h_cnt};
    assign vy = {1'b0, v_cnt};

    // Row origins are accumulated pitch by pitch; once a row would run past the
    // 10-bit coordinate space it and all rows below it are dropped.
    always_comb begin
        hit_outline = 1'b0;
        hit_cur_row = 1'b0;
        clipped     = 1'b0;
        oy          = BY0;
        for (int k = 0; k < N_ITEMS; k++) begin
            if (!clipped && (oy + ROW_H > 11'd1024)) begin
                clipped = 1'b1;
            end
            if (!clipped) begin
                if (vy >= oy && vy < oy + ROW_H && hx >= BX0 && hx < BX1 &&
                    !(vy >= oy + BRD && vy < oy + ROW_H - BRD &&
                      hx >= BX0 + BRD && hx < BX1 - BRD)) begin
                    hit_outline = 1'b1;
                end
                if (SEL_W'(k) == sel && vy >= oy + CUR_OFF && vy < oy + CUR_OFF + CUR_H) begin
                    hit_cur_row = 1'b1;
                end
                oy = oy + RP;
            end
        end
    end

    assign hit_cursor = hit_cur_row && hx >= CUR_X0 && hx < CUR_X1 &&
                        (state == LOCKED || blink_phase);
    assign hit_title  = hx >= TX0 && hx < TX1 && vy >= TY0 && vy < TY1;

    logic       rom_q;
    logic [8:0] rom_x;
    logic [4:0] rom_y;

    assign rom_x = 9'(h_cnt - 10'(TITLE_X0));
    assign rom_y = 5'(v_cnt - 10'(TITLE_Y0));

    menu_title_rom u_title_rom (
        .clk  (clk),
        .rst  (rst),
        .x    (rom_x),
        .y    (rom_y),
        .dout (rom_q)
    );

    logic        s1_valid, s1_outline, s1_cursor, s1_title;
    logic [11:0] s1_cur_col, pix;

    // sel, state and blink_phase all land in stage 1 on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_outline <= 1'b0;
            s1_cursor  <= 1'b0;
            s1_title   <= 1'b0;
            s1_cur_col <= BLACK;
        end else begin
            s1_valid   <= valid;
            s1_outline <= hit_outline;
            s1_cursor  <= hit_cursor;
            s1_title   <= hit_title;
            s1_cur_col <= (state == LOCKED) ? GREEN : RED;
        end
    end

    always_comb begin
        pix = BLACK;
        if (s1_valid) begin
            if (s1_outline) begin
                pix = WHITE;
            end else if (s1_cursor) begin
                pix = s1_cur_col;
            end else if (s1_title && rom_q) begin
                pix = WHITE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r <= 4'h0;
            g <= 4'h0;
            b <= 4'h0;
        end else begin
            {r, g, b} <= pix;
        end
    end

endmodule

// File: tb/tb_getpixel_menu.sv
// Bench for getpixel_menu: directed checks plus randomized traffic against a behavioural model.
module tb_getpixel_menu;

    localparam int N     = 4;
    localparam int X0    = 112;
    localparam int X1    = 592;
    localparam int Y0    = 88;
    localparam int PITCH = 88;
    localparam int BRD   = 5;
    localparam int BF    = 16;
    localparam int RH    = PITCH - 28;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic [9:0] h_cnt = 10'd500;
    logic [9:0] v_cnt = 10'd500;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_confirm = 1'b0, sel_ack = 1'b0;
    logic [1:0] sel;
    logic       sel_valid;
    logic [3:0] r, g, b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    getpixel_menu dut (
        .clk         (clk),
        .rst         (rst),
        .valid       (valid),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_confirm (btn_confirm),
        .sel_ack     (sel_ack),
        .sel         (sel),
        .sel_valid   (sel_valid),
        .r           (r),
        .g           (g),
        .b           (b)
    );

    function automatic bit rom_bit(int x, int y);
        return ((((x >> 3) & 1) ^ ((y >> 2) & 1)) == 1) && ((x % 8) != 7) && ((x >> 4) != y);
    endfunction

    function automatic logic [11:0] exp_pix(int h, int v, bit vld, int s, bit blink, bit locked);
        int ry, cy;
        if (!vld) return 12'h000;
        for (int k = 0; k < N; k++) begin
            ry = Y0 + k * PITCH;
            if (v >= ry && v < ry + RH && h >= X0 && h < X1 &&
                !(v >= ry + BRD && v < ry + RH - BRD && h >= X0 + BRD && h < X1 - BRD))
                return 12'hfff;
        end
        cy = Y0 + s * PITCH + RH / 2 - 8;
        if (h >= 64 && h < 90 && v >= cy && v < cy + 16) begin
            if (locked) return 12'h0f0;
            if (blink) return 12'hf00;
        end
        if (h >= 32 && h < 405 && v >= 16 && v < 39)
            return rom_bit(h - 32, v - 16) ? 12'hfff : 12'h000;
        return 12'h000;
    endfunction

    task automatic check(string name, logic [11:0] act, logic [11:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: selection/lock rules, frame blink, and a two-deep colour delay line.
    int          m_sel, m_fc;
    bit          m_locked, m_blink;
    logic [11:0] p1, p2;
    bit          cmp_on = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_sel    <= 0;
            m_fc     <= 0;
            m_locked <= 1'b0;
            m_blink  <= 1'b1;
            p1       <= 12'h000;
            p2       <= 12'h000;
        end else begin
            p2 <= p1;
            p1 <= exp_pix(int'(h_cnt), int'(v_cnt), valid, m_sel, m_blink, m_locked);
            if (h_cnt == 10'd0 && v_cnt == 10'd0) begin
                if (m_fc == BF - 1) begin
                    m_fc    <= 0;
                    m_blink <= ~m_blink;
                end else begin
                    m_fc <= m_fc + 1;
                end
            end
            if (!m_locked) begin
                if (btn_confirm) m_locked <= 1'b1;
                else if (btn_up && !btn_down) m_sel <= (m_sel + N - 1) % N;
                else if (btn_down && !btn_up) m_sel <= (m_sel + 1) % N;
            end else if (sel_ack) begin
                m_locked <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check("model_rgb", {r, g, b}, p2);
            check("model_sel", 12'(sel), 12'(m_sel));
            check("model_sel_valid", 12'(sel_valid), 12'(m_locked));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(bit u, bit d, bit c, bit a);
        btn_up = u; btn_down = d; btn_confirm = c; sel_ack = a;
        tick();
        btn_up = 0; btn_down = 0; btn_confirm = 0; sel_ack = 0;
    endtask

    task automatic frames(int n);
        for (int i = 0; i < n; i++) begin
            h_cnt = 10'd0; v_cnt = 10'd0;
            tick();
            h_cnt = 10'd500; v_cnt = 10'd500;
            tick();
        end
    endtask

    // Drive a point, confirm nothing shows after 1 clk, then the required colour after 2 clk.
    task automatic pix_check(string name, int h, int v, bit vl, logic [11:0] exp);
        h_cnt = 10'(h); v_cnt = 10'(v); valid = vl;
        tick();
        check({name, "_lat1"}, {r, g, b}, 12'h000);
        tick();
        check(name, {r, g, b}, exp);
        h_cnt = 10'd500; v_cnt = 10'd500;
        tick();
        tick();
    endtask

    int rs;

    initial begin
        repeat (3) tick();
        check("rst_sel", 12'(sel), 12'h0);
        check("rst_sel_valid", 12'(sel_valid), 12'h0);
        check("rst_rgb", {r, g, b}, 12'h000);
        rst = 1'b0;
        cmp_on = 1'b1;
        valid = 1'b1;
        tick();

        press(0, 1, 0, 0); check("down1", 12'(sel), 12'd1);
        press(0, 1, 0, 0); check("down2", 12'(sel), 12'd2);
        press(0, 1, 0, 0); check("down3", 12'(sel), 12'd3);
        press(0, 1, 0, 0); check("down_wrap", 12'(sel), 12'd0);
        press(1, 0, 0, 0); check("up_wrap", 12'(sel), 12'd3);
        press(1, 1, 0, 0); check("up_down_hold", 12'(sel), 12'd3);
        press(1, 0, 0, 0); check("up_to2", 12'(sel), 12'd2);

        press(0, 1, 1, 0);
        check("confirm_valid", 12'(sel_valid), 12'd1);
        check("confirm_sel", 12'(sel), 12'd2);
        press(1, 0, 0, 0); check("locked_ignore", 12'(sel), 12'd2);
        press(0, 0, 0, 1); check("ack_clear", 12'(sel_valid), 12'd0);
        press(1, 0, 0, 0); check("after_ack_up", 12'(sel), 12'd1);
        press(0, 0, 0, 1); check("stray_ack", 12'(sel_valid), 12'd0);
        press(1, 0, 0, 0); check("to_row0", 12'(sel), 12'd0);

        pix_check("cursor_red", 70, 120, 1, 12'hf00);
        frames(16);
        pix_check("cursor_blink_off", 70, 120, 1, 12'h000);
        press(0, 0, 1, 0);
        pix_check("cursor_green", 70, 120, 1, 12'h0f0);
        press(0, 0, 0, 1);
        pix_check("outline", 112, 90, 1, 12'hfff);
        pix_check("outline_invalid", 112, 90, 0, 12'h000);
        valid = 1'b1;

        press(1, 0, 0, 0);
        press(0, 0, 1, 0);
        check("pre_rst_sel", 12'(sel), 12'd3);
        h_cnt = 10'd112; v_cnt = 10'd90;
        tick(); tick();
        check("pre_rst_rgb", {r, g, b}, 12'hfff);
        #3 rst = 1'b1;
        #1;
        check("async_rst_sel", 12'(sel), 12'h0);
        check("async_rst_valid", 12'(sel_valid), 12'h0);
        check("async_rst_rgb", {r, g, b}, 12'h000);
        tick();
        press(0, 1, 0, 0);
        check("btn_in_rst", 12'(sel), 12'h0);
        rst = 1'b0;
        tick();
        check("rgb_1clk_after_rst", {r, g, b}, 12'h000);
        h_cnt = 10'd500; v_cnt = 10'd500;
        tick(); tick();

        frames(15);
        pix_check("blink_15", 70, 120, 1, 12'hf00);
        frames(1);
        pix_check("blink_16", 70, 120, 1, 12'h000);
        frames(15);
        pix_check("blink_31", 70, 120, 1, 12'h000);

        for (int i = 0; i < 3000; i++) begin
            rs = $urandom_range(0, 19);
            if (rs == 0) begin
                h_cnt = 10'd0; v_cnt = 10'd0;
            end else if (rs < 6) begin
                h_cnt = 10'($urandom_range(60, 94)); v_cnt = 10'($urandom_range(80, 420));
            end else if (rs < 12) begin
                h_cnt = 10'($urandom_range(100, 600)); v_cnt = 10'($urandom_range(80, 420));
            end else if (rs < 16) begin
                h_cnt = 10'($urandom_range(28, 410)); v_cnt = 10'($urandom_range(12, 42));
            end else begin
                h_cnt = 10'($urandom_range(0, 799)); v_cnt = 10'($urandom_range(0, 524));
            end
            valid       = ($urandom_range(0, 9) != 0);
            btn_up      = ($urandom_range(0, 7) == 0);
            btn_down    = ($urandom_range(0, 7) == 0);
            btn_confirm = ($urandom_range(0, 11) == 0);
            sel_ack     = ($urandom_range(0, 5) == 0);
            tick();
        end
        btn_up = 0; btn_down = 0; btn_confirm = 0; sel_ack = 0;
        h_cnt = 10'd500; v_cnt = 10'd500;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/getpixel_menu.md
GETPIXEL_MENU -- requirements
Module: getpixel_menu

Interface
REQ-001 Parameter N_ITEMS, default 4: number of selectable menu rows, 2..16.
REQ-002 Parameter SEL_W, default 2: selection index width, equal to clog2(N_ITEMS).
REQ-003 Parameter BOX_X0 / BOX_X1, default 112 / 592: horizontal extent of the menu frame in pixels.
REQ-004 Parameter BOX_Y0, default 88: top edge of the menu frame in pixels.
REQ-005 Parameter ROW_PITCH, default 88: vertical distance between row origins; BORDER, default 5: frame/outline thickness.
REQ-006 Parameter BLINK_FRAMES, default 16: number of frames per cursor blink half-period.
REQ-007 clk  in  1  pixel clock.
REQ-008 rst  in  1  reset; asynchronous, active-high.
REQ-009 valid  in  1  display-active qualifier.
REQ-010 h_cnt, v_cnt  in  10 each  current scan position.
REQ-011 btn_up, btn_down, btn_confirm  in  1 each  single-cycle debounced button pulses.
REQ-012 sel_ack  in  1  consumer acknowledge of a confirmed selection.
REQ-013 sel  out  SEL_W  current highlighted row index; row 0 is the topmost row.
REQ-014 sel_valid  out  1  confirmed selection pending.
REQ-015 r, g, b  out  4 each  registered pixel colour.

Function
REQ-016 btn_up SHALL decrement sel, wrapping from 0 to N_ITEMS-1; btn_down SHALL increment sel, wrapping from N_ITEMS-1 to 0.
REQ-017 btn_up and btn_down asserted in the same cycle SHALL leave sel unchanged.
REQ-018 btn_confirm SHALL set sel_valid on the next edge and lock sel; while locked, all button pulses SHALL be ignored.
REQ-019 btn_confirm coincident with btn_up or btn_down SHALL confirm the pre-move sel, and the move SHALL be discarded.
REQ-020 sel_valid SHALL stay high until a cycle with sel_ack high; it SHALL clear on the following edge and unlock sel.
REQ-021 sel_ack while sel_valid is low SHALL have no effect.
REQ-022 States: BROWSE (sel_valid=0) and LOCKED (sel_valid=1); BROWSE->LOCKED on btn_confirm; LOCKED->BROWSE on sel_ack.
REQ-023 The frame counter SHALL advance once per frame, when h_cnt==0 and v_cnt==0; it SHALL wrap at BLINK_FRAMES-1 and toggle blink_phase on each wrap.
REQ-024 Row k SHALL occupy y in [BOX_Y0+k*ROW_PITCH, BOX_Y0+k*ROW_PITCH+ROW_PITCH-28), x in [BOX_X0, BOX_X1).
REQ-025 Each row's BORDER-wide outline SHALL be white (fff).
REQ-026 The cursor SHALL be a 26x16 block at x=64, vertically centred on the sel row.
REQ-027 In BROWSE, the cursor SHALL be red (f00) when blink_phase=1 and absent when blink_phase=0; in LOCKED, it SHALL be green (0f0) constantly.
REQ-028 The title region x in [32,405), y in [16,39) SHALL be white where the title ROM bit is 1 and black otherwise, using ROM address x-32, y-16.
REQ-029 Priority SHALL be outline > cursor > title > black; valid=0 SHALL force 000.
REQ-030 Pipeline latency SHALL be exactly 2 clk from h_cnt/v_cnt/valid to r/g/b. Stage 1 SHALL register the region decode and issue the ROM address; stage 2 SHALL register the colour.
REQ-031 sel and blink_phase SHALL be sampled into stage 1 together, so that no pixel mixes old and new values.
REQ-032 All coordinate arithmetic SHALL be 10-bit unsigned; row origins SHALL be computed with a per-row compare loop (no multiplier), and out-of-range rows SHALL be clipped.

Reset
REQ-033 rst SHALL asynchronously clear sel=0, sel_valid=0 (BROWSE), frame counter=0, blink_phase=1, all pipeline registers, and r=g=b=0.
REQ-034 rst asserted mid-frame SHALL produce black output until 2 clk after deassertion; button pulses during rst SHALL be lost.

Structure
REQ-035 A shared package SHALL hold the colour constants (WHITE, BLACK, RED, GREEN as 12-bit), the title region bounds, the cursor geometry, and the state encoding.
REQ-036 One sub-module SHALL be used: menu_title_rom (1-cycle synchronous read, 9-bit x, 5-bit y, 1-bit out), instantiated once.

Verification
REQ-037 After reset, four btn_down pulses with N_ITEMS=4 -> sel sequence 1,2,3,0.
REQ-038 From sel=0, one btn_up -> sel=3; btn_up and btn_down in the same cycle -> sel unchanged.
REQ-039 From sel=2, btn_confirm coincident with btn_down -> sel_valid=1 and sel=2. Then btn_up is ignored, sel_ack clears sel_valid one cycle later, and the next btn_up -> sel=1.
REQ-040 Drive h_cnt=70, v_cnt=120 with sel=0 and blink_phase=1 -> r,g,b=f,0,0 exactly 2 clk later. With blink_phase=0 -> 0,0,0; in LOCKED -> 0,f,0.
REQ-041 Drive h_cnt=112, v_cnt=90 -> fff regardless of sel. With valid=0 at the same point -> 000 2 clk later.
REQ-042 Assert rst asynchronously mid-line while sel=3 and sel_valid=1 -> sel=0, sel_valid=0, and rgb=000 immediately; run 16 frames -> blink_phase toggles exactly once.
